// File: rtl/alu_op_sequencer.sv
// Initiator for a single-cycle 32-bit ALU: decodes R-type funct, sequences srl and (optionally) multiply.
// Defining ALU_MUL_EN enables the shift-add multiplier for funct 0x18; otherwise 0x18 is illegal.
module alu_op_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [5:0]         req_funct_i,
  input  logic [DATA_W-1:0]  req_a_i,
  input  logic [DATA_W-1:0]  req_b_i,
  input  logic [SHAMT_W-1:0] req_shamt_i,
  output logic [2:0]         alu_op_o,
  output logic [DATA_W-1:0]  alu_a_o,
  output logic [DATA_W-1:0]  alu_b_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               alu_zero_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DATA_W-1:0]  rsp_result_o,
  output logic               rsp_zero_o,
  output logic               rsp_illegal_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SRL1 = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SRL = 6'h02;

`ifdef ALU_MUL_EN
  localparam logic [2:0] S_MUL_ADD = 3'd4;
  localparam logic [2:0] S_MUL_DBL = 3'd5;
  localparam logic [2:0] S_MUL_SHR = 3'd6;
  localparam logic [5:0] F_MUL     = 6'h18;
  localparam int unsigned ITER_W   = $clog2(DATA_W);

  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [ITER_W-1:0] iter_q, iter_d;
`endif

  logic [2:0]         state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_illegal_q, rsp_illegal_d;
  logic               dec_legal;
  logic [2:0]         dec_op;

  // Single-pass funct decode; srl and mul are sequenced separately.
  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_ADD;
    case (req_funct_i)
      F_ADD:   dec_op = OP_ADD;
      F_SUB:   dec_op = OP_SUB;
      F_AND:   dec_op = OP_AND;
      F_OR:    dec_op = OP_OR;
      F_XOR:   dec_op = OP_XOR;
      F_NOR:   dec_op = OP_NOR;
      F_SLT:   dec_op = OP_SLT;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
`ifdef ALU_MUL_EN
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    iter_d        = iter_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_funct_i == F_SRL) begin
            // shamt 0 passes B through as 0|B
            alu_a_d = '0;
            alu_b_d = req_b_i;
            cnt_d   = req_shamt_i;
            if (req_shamt_i == '0) begin
              alu_op_d = OP_OR;
              state_d  = S_EXEC;
            end else begin
              alu_op_d = OP_SRL1;
              state_d  = S_SHIFT;
            end
          end
`ifdef ALU_MUL_EN
          else if (req_funct_i == F_MUL) begin
            acc_d    = '0;
            mcand_d  = req_a_i;
            mplier_d = req_b_i;
            iter_d   = '0;
            if (req_b_i == '0) begin
              state_d       = S_DONE;
              rsp_valid_d   = 1'b1;
              rsp_result_d  = '0;
              rsp_zero_d    = 1'b1;
              rsp_illegal_d = 1'b0;
            end else begin
              alu_op_d = OP_ADD;
              alu_a_d  = '0;
              alu_b_d  = req_a_i;
              state_d  = S_MUL_ADD;
            end
          end
`endif
          else if (dec_legal) begin
            alu_op_d = dec_op;
            alu_a_d  = req_a_i;
            alu_b_d  = req_b_i;
            state_d  = S_EXEC;
          end else begin
            state_d       = S_DONE;
            rsp_valid_d   = 1'b1;
            rsp_result_d  = '0;
            rsp_zero_d    = 1'b1;
            rsp_illegal_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        state_d       = S_DONE;
        rsp_valid_d   = 1'b1;
        rsp_result_d  = alu_result_i;
        rsp_zero_d    = alu_zero_i;
        rsp_illegal_d = 1'b0;
      end
      S_SHIFT: begin
        alu_b_d = alu_result_i;
        cnt_d   = cnt_q - SHAMT_W'(1);
        // A zero intermediate stays zero, so stop shifting early
        if (alu_zero_i || cnt_q == SHAMT_W'(1)) begin
          state_d       = S_DONE;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = alu_result_i;
          rsp_zero_d    = alu_zero_i;
          rsp_illegal_d = 1'b0;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL_ADD: begin
        if (mplier_q[0]) acc_d = alu_result_i;
        alu_op_d = OP_ADD;
        alu_a_d  = mcand_q;
        alu_b_d  = mcand_q;
        state_d  = S_MUL_DBL;
      end
      S_MUL_DBL: begin
        mcand_d  = alu_result_i;
        alu_op_d = OP_SRL1;
        alu_b_d  = mplier_q;
        state_d  = S_MUL_SHR;
      end
      S_MUL_SHR: begin
        mplier_d = alu_result_i;
        iter_d   = iter_q + ITER_W'(1);
        if (alu_zero_i || iter_q == ITER_W'(DATA_W - 1)) begin
          state_d       = S_DONE;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = acc_q;
          rsp_zero_d    = (acc_q == '0);
          rsp_illegal_d = 1'b0;
        end else begin
          alu_op_d = OP_ADD;
          alu_a_d  = acc_q;
          alu_b_d  = mcand_q;
          state_d  = S_MUL_ADD;
        end
      end
`endif
      S_DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      alu_op_q      <= OP_ADD;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      iter_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
`ifdef ALU_MUL_EN
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      iter_q        <= iter_d;
`endif
    end
  end

  assign req_ready_o   = req_ready_q;
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table plus hold and mid-op reset sequences.
// Includes a behavioural model of the external single-cycle ALU.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_shamt;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_funct_i(req_funct), .req_a_i(req_a), .req_b_i(req_b), .req_shamt_i(req_shamt),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_illegal_o(rsp_illegal)
  );

  // External ALU model
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a ^ alu_b;
      3'b100:  alu_result = ~(alu_a | alu_b);
      3'b101:  alu_result = alu_b >> 1;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [31:0] r, input logic z,
                              input logic il, input int lat, input int hold);
    vec_t v;
    v.funct = f; v.a = a; v.b = b; v.shamt = sh;
    v.exp_res = r; v.exp_zero = z; v.exp_ill = il; v.exp_lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, measure edges from accept (accept edge = 1) to rsp_valid, then consume.
  task automatic run_op(input vec_t v, input int idx);
    int edges;
    @(negedge clk);
    check($sformatf("v%0d_req_ready_idle", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_funct = v.funct; req_a = v.a; req_b = v.b; req_shamt = v.shamt;
    rsp_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_funct = 6'h00; req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D; req_shamt = 5'd7;
    while (!rsp_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check($sformatf("v%0d_latency", idx), 32'(edges), 32'(v.exp_lat));
    check($sformatf("v%0d_result", idx), rsp_result, v.exp_res);
    check($sformatf("v%0d_zero", idx), 32'(rsp_zero), 32'(v.exp_zero));
    check($sformatf("v%0d_illegal", idx), 32'(rsp_illegal), 32'(v.exp_ill));
    check($sformatf("v%0d_req_ready_busy", idx), 32'(req_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_hold%0d_valid", idx, h), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d_hold%0d_result", idx, h), rsp_result, v.exp_res);
      check($sformatf("v%0d_hold%0d_flags", idx, h), {30'd0, rsp_zero, rsp_illegal},
            {30'd0, v.exp_zero, v.exp_ill});
      check($sformatf("v%0d_hold%0d_req_ready", idx, h), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_consumed", idx), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d_req_ready_back", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0; req_shamt = '0;
    rsp_ready = 1'b0;

    vecs.push_back(mk(6'h20, 32'd5,          32'd7,          5'd0,  32'd12,         1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h22, 32'h1234,       32'h1234,       5'd0,  32'd0,          1'b1, 1'b0, 2, 0));
    vecs.push_back(mk(6'h2A, 32'd3,          32'd9,          5'd0,  32'd1,          1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h27, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h24, 32'hF0F0_1234,  32'h0FF0_FFFF,  5'd0,  32'h00F0_1234,  1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h25, 32'hF000_0000,  32'h0000_000F,  5'd0,  32'hF000_000F,  1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h26, 32'hFFFF_0000,  32'h0F0F_0F0F,  5'd0,  32'hF0F0_0F0F,  1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h2A, 32'd9,          32'd3,          5'd0,  32'd0,          1'b1, 1'b0, 2, 0));
    vecs.push_back(mk(6'h2A, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0, 2, 0));
    vecs.push_back(mk(6'h20, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0, 2, 0));
    vecs.push_back(mk(6'h22, 32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h02, 32'h1,          32'h8000_0000,  5'd4,  32'h0800_0000,  1'b0, 1'b0, 5, 0));
    vecs.push_back(mk(6'h02, 32'hFFFF,       32'hA5,         5'd0,  32'hA5,         1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(6'h02, 32'h0,          32'h1,          5'd31, 32'd0,          1'b1, 1'b0, 2, 0));
    vecs.push_back(mk(6'h02, 32'h0,          32'h8000_0000,  5'd31, 32'd1,          1'b0, 1'b0, 32, 0));
    vecs.push_back(mk(6'h3F, 32'd11,         32'd22,         5'd0,  32'd0,          1'b1, 1'b1, 1, 5));
`ifdef ALU_MUL_EN
    vecs.push_back(mk(6'h18, 32'd6,          32'd7,          5'd0,  32'd42,         1'b0, 1'b0, 10, 0));
    vecs.push_back(mk(6'h18, 32'hFFFF_FFFF,  32'd2,          5'd0,  32'hFFFF_FFFE,  1'b0, 1'b0, 7, 0));
    vecs.push_back(mk(6'h18, 32'h1234,       32'd0,          5'd0,  32'd0,          1'b1, 1'b0, 1, 0));
    vecs.push_back(mk(6'h18, 32'h1_0000,     32'h1_0000,     5'd0,  32'd0,          1'b1, 1'b0, 52, 0));
`else
    vecs.push_back(mk(6'h18, 32'd6,          32'd7,          5'd0,  32'd0,          1'b1, 1'b1, 1, 0));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd2);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_fields", {30'd0, rsp_zero, rsp_illegal}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

    // Reset in the middle of a long srl discards the operation
    @(negedge clk);
    req_valid = 1'b1; req_funct = 6'h02; req_a = '0; req_b = 32'hFFFF_FFFF; req_shamt = 5'd20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(req_ready), 32'd0);
    check("midrst_no_rsp_yet", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_alu_op", 32'(alu_op), 32'd2);
    check("midrst_alu_b", alu_b, 32'd0);
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_stays_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    end

    run_op(mk(6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 2, 0), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
